// File: rtl/sub_serial.sv
// ============================================================================
// Module  : sub_serial
// Brief   : Multi-cycle subtractor, C bits per cycle, with borrow/ovf/zero flags.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sub_serial #(
    parameter int W = 32,
    parameter int C = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] out0,
    output logic         borrow,
    output logic         ovf,
    output logic         zero
);

    localparam int K  = W / C;
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] c_last = IW'(K - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic          r_sa;
    logic          r_sb;
    logic          r_carry;
    logic [IW-1:0] r_idx;
    logic [C:0]    w_sum;
    logic [W-1:0]  w_res;
    logic          w_last;

    // Operands are shifted right so the active chunk always sits in bits [C-1:0].
    assign w_sum  = {1'b0, r_a[C-1:0]} + {1'b0, ~r_b[C-1:0]} + {{C{1'b0}}, r_carry};
    assign w_last = (r_idx == c_last);

    // Partial result accumulates from the top down; only committed to out0 at the end.
    generate
        if (K > 1) begin : g_multi
            logic [W-C-1:0] r_acc;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_acc <= '0;
                end else if (r_state == c_run) begin
                    r_acc <= w_res[W-1:C];
                end
            end
            assign w_res = {w_sum[C-1:0], r_acc};
        end else begin : g_single
            assign w_res = w_sum[C-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (start)  w_state_nxt = c_run;
            c_run:   if (w_last) w_state_nxt = c_done;
            c_done:  w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    always_comb begin
        busy = (r_state != c_idle);
        done = (r_state == c_done);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            out0    <= '0;
            borrow  <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b1;
        end else if (r_state == c_idle && start) begin
            r_a     <= in0;
            r_b     <= in1;
            r_sa    <= in0[W-1];
            r_sb    <= in1[W-1];
            r_carry <= 1'b1;
            r_idx   <= '0;
        end else if (r_state == c_run) begin
            r_a     <= r_a >> C;
            r_b     <= r_b >> C;
            r_carry <= w_sum[C];
            r_idx   <= r_idx + IW'(1);
            if (w_last) begin
                out0   <= w_res;
                borrow <= ~w_sum[C];
                ovf    <= (r_sa != r_sb) && (w_res[W-1] != r_sa);
                zero   <= (w_res == '0);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sub_serial.sv
// ============================================================================
// Module  : tb_sub_serial
// Brief   : Directed self-checking bench for sub_serial (W=32, C=8).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sub_serial;

    localparam int W = 32;
    localparam int C = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] in0;
    logic [W-1:0] in1;
    logic         busy;
    logic         done;
    logic [W-1:0] out0;
    logic         borrow;
    logic         ovf;
    logic         zero;

    int vectors     = 0;
    int miscompares = 0;

    // Last completed result as the bench expects it to be held
    logic [W-1:0] m_out;
    logic         m_zero;

    sub_serial #(.W(W), .C(C)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .in0    (in0),
        .in1    (in1),
        .busy   (busy),
        .done   (done),
        .out0   (out0),
        .borrow (borrow),
        .ovf    (ovf),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accept a-b, scramble inputs during RUN, expect done exactly 4 edges later
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] r, input logic bo, input logic ov,
                          input logic z, input string tag);
        start = 1'b1;
        in0   = a;
        in1   = b;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in0 = $urandom;
            in1 = $urandom;
            tick();
            chk({tag, "_run_busy"}, W'(busy), W'(1));
            chk({tag, "_run_done"}, W'(done), W'(0));
            chk({tag, "_run_out0"}, out0, m_out);
            chk({tag, "_run_zero"}, W'(zero), W'(m_zero));
        end
        tick();
        chk({tag, "_done"},   W'(done),   W'(1));
        chk({tag, "_busy"},   W'(busy),   W'(1));
        chk({tag, "_out0"},   out0,       r);
        chk({tag, "_borrow"}, W'(borrow), W'(bo));
        chk({tag, "_ovf"},    W'(ovf),    W'(ov));
        chk({tag, "_zero"},   W'(zero),   W'(z));
        m_out  = r;
        m_zero = z;
        tick();
        chk({tag, "_idle_done"}, W'(done), W'(0));
        chk({tag, "_idle_busy"}, W'(busy), W'(0));
        chk({tag, "_idle_out0"}, out0,     r);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b1;
        in0    = '0;
        in1    = '0;
        m_out  = '0;
        m_zero = 1'b1;
        tick();
        tick();
        chk("rst_busy",   W'(busy),   W'(0));
        chk("rst_done",   W'(done),   W'(0));
        chk("rst_out0",   out0,       '0);
        chk("rst_borrow", W'(borrow), W'(0));
        chk("rst_ovf",    W'(ovf),    W'(0));
        chk("rst_zero",   W'(zero),   W'(1));
        rst = 1'b0;

        run_op(32'd5, 32'd3, 32'h0000_0002, 1'b0, 1'b0, 1'b0, "5m3");
        run_op(32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, "3m5");
        run_op(32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, "minm1");
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1'b0, "maxmneg1");
        run_op(32'h1234_5678, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 1'b1, "eq");
        run_op(32'd9, 32'd4, 32'd5, 1'b0, 1'b0, 1'b0, "9m4");

        // start held high through RUN with new operands: one done, re-accept 2 edges later
        start = 1'b1;
        in0   = 32'd9;
        in1   = 32'd4;
        tick();
        in0 = 32'd100;
        in1 = 32'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_run_done", W'(done), W'(0));
        end
        tick();
        chk("hold_done", W'(done), W'(1));
        chk("hold_out0", out0,     32'd5);
        tick();
        chk("hold_idle_done", W'(done), W'(0));
        chk("hold_idle_busy", W'(busy), W'(0));
        tick();
        chk("hold_reaccept_busy", W'(busy), W'(1));
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        tick();
        chk("hold2_done", W'(done), W'(1));
        chk("hold2_out0", out0,     32'd99);
        tick();
        m_out  = 32'd99;
        m_zero = 1'b0;

        // reset on the 2nd RUN edge aborts the operation
        start = 1'b1;
        in0   = 32'd9;
        in1   = 32'd4;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("abort_busy", W'(busy), W'(0));
        chk("abort_done", W'(done), W'(0));
        chk("abort_out0", out0,     '0);
        chk("abort_zero", W'(zero), W'(1));
        rst    = 1'b0;
        m_out  = '0;
        m_zero = 1'b1;
        run_op(32'd7, 32'd7, 32'h0, 1'b0, 1'b0, 1'b1, "7m7");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sub_serial.md
SUB_SERIAL -- requirements
Module: sub_serial

Interface
REQ-001 The block SHALL have parameter W, default 32, meaning the operand and result width in bits.
REQ-002 The block SHALL have parameter C, default 8, meaning the bits processed per cycle; W SHALL be an integer multiple of C, with W/C = K.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port start, input, 1 bit: request to begin a subtraction.
REQ-006 Port in0, input, W bits: minuend, sampled only on the start-accept edge.
REQ-007 Port in1, input, W bits: subtrahend, sampled only on the start-accept edge.
REQ-008 Port busy, output, 1 bit: high while in RUN or DONE.
REQ-009 Port done, output, 1 bit: one-cycle pulse, high in DONE only.
REQ-010 Port out0, output, W bits: difference in0 - in1, modulo 2^W.
REQ-011 Port borrow, output, 1 bit: high when in0 < in1 (unsigned).
REQ-012 Port ovf, output, 1 bit: two's-complement signed overflow of the subtraction.
REQ-013 Port zero, output, 1 bit: high when out0 == 0.

Function
REQ-014 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-015 IDLE with start=1 at an edge SHALL accept the request: latch in0/in1, set carry=1, set chunk index=0, go to RUN.
REQ-016 The computation SHALL be in0 + ~in1 + 1, processed in C-bit chunks from LSB to MSB, one chunk per RUN edge, carrying the chunk carry-out to the next chunk.
REQ-017 On the K-th RUN edge (last chunk), the state SHALL become DONE; all result bits and flags SHALL be valid from that edge.
REQ-018 Latency: done SHALL be high in the cycle following the K-th edge after the accept edge (K=4 for the defaults).
REQ-019 DONE SHALL always go to IDLE on the next edge; the earliest next accept SHALL be the edge after that.
REQ-020 start SHALL be ignored in RUN and DONE, and SHALL NOT alter latched operands or progress.
REQ-021 Changes on in0/in1 after the accept edge SHALL NOT affect the result.
REQ-022 borrow SHALL equal the inverse of the final MSB-chunk carry-out.
REQ-023 ovf SHALL be 1 iff in0[W-1] != in1[W-1] and out0[W-1] != in0[W-1].
REQ-024 zero SHALL be computed from the final W-bit result.
REQ-025 out0, borrow, ovf and zero SHALL hold their last completed values in IDLE until the next completion; partial results SHALL NOT be visible on out0 during RUN.
REQ-026 busy SHALL be low only in IDLE; done SHALL never be high for more than one consecutive cycle.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE and clear busy, done, out0, borrow, ovf and the chunk index to 0, and set zero to 1, consistent with out0=0.
REQ-028 rst SHALL take priority over start and over any in-progress operation; an aborted operation SHALL produce no done pulse.
REQ-029 If start=1 on the edge after rst deasserts, it SHALL be accepted normally.

Verification (W=32, C=8)
REQ-030 in0=5, in1=3, start pulse -> done 4 edges after accept; out0=0x00000002, borrow=0, ovf=0, zero=0.
REQ-031 in0=3, in1=5 -> out0=0xFFFFFFFE, borrow=1, ovf=0, zero=0.
REQ-032 in0=0x80000000, in1=1 -> out0=0x7FFFFFFF, borrow=0, ovf=1; in0=0x7FFFFFFF, in1=0xFFFFFFFF -> out0=0x80000000, borrow=1, ovf=1.
REQ-033 in0=in1=0x12345678 -> out0=0, zero=1, borrow=0; after that, start with 9-4 -> zero returns to 0 only at the new done.
REQ-034 Accept 9-4, then hold start=1 and change in0/in1 to 100/1 during RUN -> single done with out0=5; next accept occurs 2 edges after done.
REQ-035 Accept 9-4, assert rst on the 2nd RUN edge -> no done, busy=0, out0=0, zero=1; start next cycle with 7-7 -> out0=0, zero=1, done after 4 edges.
